// File: rtl/if_trace_buffer_if.sv
// Instruction-fetch snoop and trace-drain signal bundle for if_trace_buffer.
// The core side drives the fetch handshake. The debug side consumes records through the FWFT port.
`default_nettype none

interface if_trace_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 32,
  parameter int TAG_WIDTH  = 16,
  parameter int DEPTH      = 128
);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  trace_en;
  logic                  instr_req;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_gnt;
  logic                  instr_rvalid;
  logic [DATA_WIDTH-1:0] instr_rdata;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_instr;
  logic [TIME_WIDTH-1:0] rd_t_start;
  logic [TIME_WIDTH-1:0] rd_t_end;
  logic [CNT_WIDTH-1:0]  count;
  logic [15:0]           overflow_cnt;
  logic                  pend_err;

  modport master (
    output trace_en, instr_req, instr_addr, instr_gnt, instr_rvalid, instr_rdata, rd_ready,
    input  rd_valid, rd_tag, rd_addr, rd_instr, rd_t_start, rd_t_end, count, overflow_cnt, pend_err
  );

  modport slave (
    input  trace_en, instr_req, instr_addr, instr_gnt, instr_rvalid, instr_rdata, rd_ready,
    output rd_valid, rd_tag, rd_addr, rd_instr, rd_t_start, rd_t_end, count, overflow_cnt, pend_err
  );
endinterface

`default_nettype wire

// File: rtl/if_trace_buffer.sv
// Instruction-fetch trace unit: snoops req/gnt/rvalid and tracks pipelined fetches.
// Completed fetches are stored as timestamped records in a circular buffer with an FWFT drain port.
`default_nettype none

module if_trace_buffer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIME_WIDTH      = 32,
  parameter int TAG_WIDTH       = 16,
  parameter int DEPTH           = 128,
  parameter int MAX_OUTSTANDING = 2,
  parameter int OVERWRITE       = 0
) (
  input  logic               clk,
  input  logic               rst,
  if_trace_buffer_if.slave   bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int BPW = $clog2(DEPTH);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0]  P_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [PCW-1:0] P_MAX  = PCW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]  B_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic [TIME_WIDTH-1:0] t_start;
    logic [TIME_WIDTH-1:0] t_end;
  } rec_t;

  logic [TIME_WIDTH-1:0] cyc_q, cyc_d;
  logic                  lat_vld_q, lat_vld_d;
  logic [TIME_WIDTH-1:0] lat_ts_q, lat_ts_d;
  logic [ADDR_WIDTH-1:0] p_addr_q [MAX_OUTSTANDING];
  logic [TIME_WIDTH-1:0] p_ts_q   [MAX_OUTSTANDING];
  logic [PW-1:0]         p_rd_q, p_rd_d, p_wr_q, p_wr_d;
  logic [PCW-1:0]        p_cnt_q, p_cnt_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  rec_t                  mem_q [DEPTH];
  logic [BPW-1:0]        b_rd_q, b_rd_d, b_wr_q, b_wr_d;
  logic [CW-1:0]         b_cnt_q, b_cnt_d;
  logic [15:0]           ovf_q, ovf_d;
  logic                  err_q, err_d;

  logic                  w_grant, w_p_empty, w_p_full, w_p_pop, w_p_push;
  logic                  w_rd_valid, w_rd_pop, w_b_full, w_drop, w_store;
  logic [TIME_WIDTH-1:0] w_t_start;
  rec_t                  w_rec, w_head;

  assign w_grant    = bus.instr_req && bus.instr_gnt && bus.trace_en;
  assign w_p_empty  = (p_cnt_q == '0);
  assign w_p_full   = (p_cnt_q == P_MAX);
  assign w_p_pop    = bus.instr_rvalid && !w_p_empty;
  // A full pending FIFO still accepts a grant when the oldest entry retires in the same cycle.
  assign w_p_push   = w_grant && (!w_p_full || w_p_pop);
  assign w_t_start  = lat_vld_q ? lat_ts_q : cyc_q;

  assign w_rd_valid = (b_cnt_q != '0);
  assign w_rd_pop   = w_rd_valid && bus.rd_ready;
  assign w_b_full   = (b_cnt_q == B_FULL);
  assign w_drop     = w_p_pop && w_b_full && !w_rd_pop;
  assign w_store    = w_p_pop && (!w_drop || (OVERWRITE != 0));

  assign w_rec  = '{tag: tag_q, addr: p_addr_q[p_rd_q], instr: bus.instr_rdata,
                    t_start: p_ts_q[p_rd_q], t_end: cyc_q};
  assign w_head = mem_q[b_rd_q];

  always_comb begin
    cyc_d     = cyc_q + 1'b1;
    lat_vld_d = lat_vld_q;
    lat_ts_d  = lat_ts_q;
    p_rd_d    = p_rd_q;
    p_wr_d    = p_wr_q;
    p_cnt_d   = p_cnt_q + PCW'(w_p_push) - PCW'(w_p_pop);
    tag_d     = tag_q + TAG_WIDTH'(w_p_pop);
    b_rd_d    = b_rd_q;
    b_wr_d    = b_wr_q;
    b_cnt_d   = b_cnt_q + CW'(w_store && !w_drop) - CW'(w_rd_pop);
    ovf_d     = ovf_q;
    err_d     = err_q | (w_grant && w_p_full && !w_p_pop) | (bus.instr_rvalid && w_p_empty);

    if (w_grant) begin
      lat_vld_d = 1'b0;
    end else if (bus.instr_req && bus.trace_en && !lat_vld_q) begin
      lat_vld_d = 1'b1;
      lat_ts_d  = cyc_q;
    end

    if (w_p_pop)  p_rd_d = (p_rd_q == P_LAST) ? '0 : p_rd_q + 1'b1;
    if (w_p_push) p_wr_d = (p_wr_q == P_LAST) ? '0 : p_wr_q + 1'b1;

    if (w_store) b_wr_d = b_wr_q + 1'b1;
    // An overwrite on a full buffer discards the oldest record by moving the head past it.
    if (w_rd_pop || (w_store && w_drop)) b_rd_d = b_rd_q + 1'b1;
    if (w_drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q     <= '0;
      lat_vld_q <= 1'b0;
      lat_ts_q  <= '0;
      p_rd_q    <= '0;
      p_wr_q    <= '0;
      p_cnt_q   <= '0;
      tag_q     <= '0;
      b_rd_q    <= '0;
      b_wr_q    <= '0;
      b_cnt_q   <= '0;
      ovf_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        p_addr_q[i] <= '0;
        p_ts_q[i]   <= '0;
      end
    end else begin
      cyc_q     <= cyc_d;
      lat_vld_q <= lat_vld_d;
      lat_ts_q  <= lat_ts_d;
      p_rd_q    <= p_rd_d;
      p_wr_q    <= p_wr_d;
      p_cnt_q   <= p_cnt_d;
      tag_q     <= tag_d;
      b_rd_q    <= b_rd_d;
      b_wr_q    <= b_wr_d;
      b_cnt_q   <= b_cnt_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      if (w_p_push) begin
        p_addr_q[p_wr_q] <= bus.instr_addr;
        p_ts_q[p_wr_q]   <= w_t_start;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) mem_q[b_wr_q] <= w_rec;
  end

  assign bus.rd_valid     = w_rd_valid;
  assign bus.rd_tag       = w_rd_valid ? w_head.tag     : '0;
  assign bus.rd_addr      = w_rd_valid ? w_head.addr    : '0;
  assign bus.rd_instr     = w_rd_valid ? w_head.instr   : '0;
  assign bus.rd_t_start   = w_rd_valid ? w_head.t_start : '0;
  assign bus.rd_t_end     = w_rd_valid ? w_head.t_end   : '0;
  assign bus.count        = b_cnt_q;
  assign bus.overflow_cnt = ovf_q;
  assign bus.pend_err     = err_q;

endmodule

`default_nettype wire
